status_register_unit: RTL and testbench

- Producer end of the 4-bit status bus that the condition checker consumes.
- Sits in the EXE stage and computes N, Z, C and V for the current flag-setting instruction.
- Commits the flags to the architectural status register on the clock edge.
- Provides a forwarded "next status" value so an ID-stage condition evaluation sees flags written by the instruction currently in EXE.

---
 rtl/status_register_unit.sv | 112 +++++++++++
 tb/tb_status_register_unit.sv | 103 ++++++++++
 2 files changed

// File: rtl/status_register_unit.sv
// EXE-stage NZCV generator: forwards flags combinationally and commits them on the next edge.
// Latency: 1 cycle to status_register; freeze holds the commit, flush kills it.
module status_register_unit #(
    parameter int WORD_LEN    = 32,
    parameter int EXE_CMD_LEN = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   freeze,
    input  logic                   flush,
    input  logic                   valid_in,
    input  logic                   s_in,
    input  logic [EXE_CMD_LEN-1:0] exe_cmd,
    input  logic [WORD_LEN-1:0]    val1,
    input  logic [WORD_LEN-1:0]    val2,
    output logic [3:0]             status_register,
    output logic [3:0]             status_next,
    output logic                   flag_write,
    output logic                   flag_pending
);

    localparam logic [EXE_CMD_LEN-1:0] CMD_MOV = EXE_CMD_LEN'(4'b0001);
    localparam logic [EXE_CMD_LEN-1:0] CMD_ADD = EXE_CMD_LEN'(4'b0010);
    localparam logic [EXE_CMD_LEN-1:0] CMD_ADC = EXE_CMD_LEN'(4'b0011);
    localparam logic [EXE_CMD_LEN-1:0] CMD_SUB = EXE_CMD_LEN'(4'b0100);
    localparam logic [EXE_CMD_LEN-1:0] CMD_SBC = EXE_CMD_LEN'(4'b0101);
    localparam logic [EXE_CMD_LEN-1:0] CMD_AND = EXE_CMD_LEN'(4'b0110);
    localparam logic [EXE_CMD_LEN-1:0] CMD_ORR = EXE_CMD_LEN'(4'b0111);
    localparam logic [EXE_CMD_LEN-1:0] CMD_EOR = EXE_CMD_LEN'(4'b1000);
    localparam logic [EXE_CMD_LEN-1:0] CMD_MVN = EXE_CMD_LEN'(4'b1001);

    logic                cin;
    logic                v_cur;
    logic                legal;
    logic                is_add;
    logic                is_sub;
    logic [WORD_LEN:0]   sum;
    logic [WORD_LEN-1:0] res;
    logic                c_new;
    logic                v_new;
    logic [3:0]          flags;
    logic                commit;

    assign cin   = status_register[2];
    assign v_cur = status_register[0];

    // Subtraction is val1 + ~val2 + carry, so the top sum bit is directly "no borrow".
    always_comb begin
        legal  = 1'b1;
        is_add = 1'b0;
        is_sub = 1'b0;
        sum    = '0;
        res    = '0;
        unique case (exe_cmd)
            CMD_MOV: res = val2;
            CMD_MVN: res = ~val2;
            CMD_AND: res = val1 & val2;
            CMD_ORR: res = val1 | val2;
            CMD_EOR: res = val1 ^ val2;
            CMD_ADD: begin
                is_add = 1'b1;
                sum    = {1'b0, val1} + {1'b0, val2};
            end
            CMD_ADC: begin
                is_add = 1'b1;
                sum    = {1'b0, val1} + {1'b0, val2} + {{WORD_LEN{1'b0}}, cin};
            end
            CMD_SUB: begin
                is_sub = 1'b1;
                sum    = {1'b0, val1} + {1'b0, ~val2} + {{WORD_LEN{1'b0}}, 1'b1};
            end
            CMD_SBC: begin
                is_sub = 1'b1;
                sum    = {1'b0, val1} + {1'b0, ~val2} + {{WORD_LEN{1'b0}}, cin};
            end
            default: legal = 1'b0;
        endcase
        if (is_add || is_sub) begin
            res = sum[WORD_LEN-1:0];
        end
    end

    always_comb begin
        c_new = cin;
        v_new = v_cur;
        if (is_add) begin
            c_new = sum[WORD_LEN];
            v_new = (val1[WORD_LEN-1] == val2[WORD_LEN-1]) && (res[WORD_LEN-1] != val1[WORD_LEN-1]);
        end else if (is_sub) begin
            c_new = sum[WORD_LEN];
            v_new = (val1[WORD_LEN-1] != val2[WORD_LEN-1]) && (res[WORD_LEN-1] != val1[WORD_LEN-1]);
        end
    end

    assign flags        = {(res == '0), c_new, res[WORD_LEN-1], v_new};
    assign flag_pending = valid_in & s_in & legal & ~flush;
    assign commit       = flag_pending & ~freeze;
    assign status_next  = flag_pending ? flags : status_register;

    always_ff @(posedge clk) begin
        if (rst) begin
            status_register <= 4'b0000;
            flag_write      <= 1'b0;
        end else begin
            flag_write <= commit;
            if (commit) begin
                status_register <= flags;
            end
        end
    end

endmodule

// File: tb/tb_status_register_unit.sv
// Directed-vector bench for status_register_unit; expected flags are hand-computed {z,c,n,v}.
module tb_status_register_unit;

    localparam logic [3:0] MOV = 4'b0001, ADD = 4'b0010, ADC = 4'b0011, SUB = 4'b0100,
                           SBC = 4'b0101, AND = 4'b0110, ILL = 4'b1111;

    logic        clk = 1'b0;
    logic        rst, freeze, flush, valid_in, s_in;
    logic [3:0]  exe_cmd;
    logic [31:0] val1, val2;
    logic [3:0]  status_register, status_next;
    logic        flag_write, flag_pending;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    status_register_unit #(.WORD_LEN(32), .EXE_CMD_LEN(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .flush           (flush),
        .valid_in        (valid_in),
        .s_in            (s_in),
        .exe_cmd         (exe_cmd),
        .val1            (val1),
        .val2            (val2),
        .status_register (status_register),
        .status_next     (status_next),
        .flag_write      (flag_write),
        .flag_pending    (flag_pending)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %b, expected %b", tag, obs, exp_v);
        end
    endtask

    // Drive one instruction, check the forward before the edge and the commit after it.
    task automatic vec(input string tag, input logic r, input logic [3:0] cmd,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic v, input logic s, input logic frz, input logic fl,
                       input logic [3:0] e_next, input logic e_pend,
                       input logic [3:0] e_sr, input logic e_fw);
        rst = r; exe_cmd = cmd; val1 = a; val2 = b;
        valid_in = v; s_in = s; freeze = frz; flush = fl;
        #1;
        if (!r) begin
            chk({tag, ".next"}, status_next, e_next);
            chk({tag, ".pend"}, {3'b000, flag_pending}, {3'b000, e_pend});
        end
        @(posedge clk);
        #1;
        chk({tag, ".sr"}, status_register, e_sr);
        chk({tag, ".fw"}, {3'b000, flag_write}, {3'b000, e_fw});
    endtask

    initial begin
        rst = 1'b1; freeze = 1'b0; flush = 1'b0; valid_in = 1'b1; s_in = 1'b1;
        exe_cmd = ADD; val1 = 32'h7FFF_FFFF; val2 = 32'h1;
        @(posedge clk);
        #1;

        vec("rst0", 1, ADD, 32'h7FFF_FFFF, 32'h1, 1, 1, 0, 0, 4'b0000, 0, 4'b0000, 0);
        vec("rst1", 1, ADD, 32'h7FFF_FFFF, 32'h1, 1, 1, 0, 0, 4'b0000, 0, 4'b0000, 0);

        vec("add_ovf", 0, ADD, 32'h7FFF_FFFF, 32'h1, 1, 1, 0, 0, 4'b0011, 1, 4'b0011, 1);
        vec("sub_eq",  0, SUB, 32'd5, 32'd5, 1, 1, 0, 0, 4'b1100, 1, 4'b1100, 1);
        vec("sub_neg", 0, SUB, 32'd3, 32'd5, 1, 1, 0, 0, 4'b0010, 1, 4'b0010, 1);
        vec("sub_v",   0, SUB, 32'h8000_0000, 32'h1, 1, 1, 0, 0, 4'b0101, 1, 4'b0101, 1);
        vec("and_zero", 0, AND, 32'h0, 32'h0, 1, 1, 0, 0, 4'b1101, 1, 4'b1101, 1);

        vec("s_off",  0, ADD, 32'h1, 32'h1, 1, 0, 0, 0, 4'b1101, 0, 4'b1101, 0);
        vec("illegal", 0, ILL, 32'h1, 32'h1, 1, 1, 0, 0, 4'b1101, 0, 4'b1101, 0);
        vec("flush",  0, ADD, 32'h1, 32'h1, 1, 1, 0, 1, 4'b1101, 0, 4'b1101, 0);
        vec("invalid", 0, ADD, 32'h1, 32'h1, 0, 1, 0, 0, 4'b1101, 0, 4'b1101, 0);

        for (int i = 0; i < 3; i++) begin
            vec($sformatf("freeze%0d", i), 0, ADD, 32'h1, 32'h1, 1, 1, 1, 0, 4'b0000, 1, 4'b1101, 0);
        end
        vec("unfreeze", 0, ADD, 32'h1, 32'h1, 1, 1, 0, 0, 4'b0000, 1, 4'b0000, 1);

        vec("mov_neg", 0, MOV, 32'h0, 32'h8000_0000, 1, 1, 0, 0, 4'b0010, 1, 4'b0010, 1);
        vec("fl_frz", 0, SUB, 32'd5, 32'd5, 1, 1, 1, 1, 4'b0010, 0, 4'b0010, 0);
        vec("adc_c0", 0, ADC, 32'hFFFF_FFFF, 32'h0, 1, 1, 0, 0, 4'b0010, 1, 4'b0010, 1);

        vec("set_c", 0, SUB, 32'd5, 32'd5, 1, 1, 0, 0, 4'b1100, 1, 4'b1100, 1);
        vec("adc",   0, ADC, 32'hFFFF_FFFF, 32'h0, 1, 1, 0, 0, 4'b1100, 1, 4'b1100, 1);
        vec("sbc",   0, SBC, 32'h0, 32'h0, 1, 1, 0, 0, 4'b1100, 1, 4'b1100, 1);
        vec("sbc_c0_prep", 0, SUB, 32'd3, 32'd5, 1, 1, 0, 0, 4'b0010, 1, 4'b0010, 1);
        vec("sbc_c0", 0, SBC, 32'd5, 32'd3, 1, 1, 0, 0, 4'b0100, 1, 4'b0100, 1);

        vec("rst_mid", 1, ADD, 32'h7FFF_FFFF, 32'h1, 1, 1, 0, 0, 4'b0000, 0, 4'b0000, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
